// File: rtl/csa_pipe_addsub_if.sv
// csa_pipe_addsub_if
//   Handshake and data bundle for csa_pipe_addsub.
//   Input side:  in_valid/in_ready, din1, din2, sub, carry_in
//   Output side: out_valid/out_ready, dout, carry_out, overflow, zero
//   master = producer/consumer environment, slave = adder block.
interface csa_pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, din1, din2, sub, carry_in, out_ready,
    input  in_ready, out_valid, dout, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, din1, din2, sub, carry_in, out_ready,
    output in_ready, out_valid, dout, carry_out, overflow, zero
  );
endinterface

// File: rtl/csa_pipe_addsub.sv
// csa_pipe_addsub
//   Pipelined carry-select adder/subtractor with valid/ready flow control.
//   The word is cut into WIDTH/BLK blocks; each of the STAGES pipeline stages
//   resolves WIDTH/BLK/STAGES consecutive blocks (LSB first). Block 0 ripples
//   from the carry-in, every other block precomputes both carry cases and the
//   incoming carry picks one. The carry between stages is registered.
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    csa_pipe_addsub_if.slave (operands, mode, handshake, result, flags)
module csa_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 8,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  csa_pipe_addsub_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int BPS  = NBLK / STAGES;
  localparam int SW   = BPS * BLK;

  logic             adv;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

  // Single shared enable: the pipe only moves when the output slot is free.
  assign adv          = ~g_stage[STAGES-1].v_q | bus.out_ready;
  assign bus.in_ready = adv & rst_n;

  assign eff_b   = bus.sub ? ~bus.din2 : bus.din2;
  assign eff_cin = bus.carry_in ^ bus.sub;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // a_in/b_in carry only the slices not yet consumed by earlier stages;
    // r_d accumulates the result bits resolved so far.
    localparam int WS = WIDTH - s * SW;
    localparam int RW = (s + 1) * SW;

    logic [WS-1:0]         a_in;
    logic [WS-1:0]         b_in;
    logic                  c_in;
    logic                  v_in;
    logic [BPS-1:0][BLK-1:0] blk_sum;
    logic [RW-1:0]         r_d;
    logic                  v_q;
    logic                  c_q;
    logic [RW-1:0]         r_q;

    if (s == 0) begin : g_src
      assign a_in = bus.din1;
      assign b_in = eff_b;
      assign c_in = eff_cin;
      assign v_in = bus.in_valid & bus.in_ready;
      assign r_d  = blk_sum;
    end else begin : g_src
      assign a_in = g_stage[s-1].g_hold.a_q;
      assign b_in = g_stage[s-1].g_hold.b_q;
      assign c_in = g_stage[s-1].c_q;
      assign v_in = g_stage[s-1].v_q;
      assign r_d  = {blk_sum, g_stage[s-1].r_q};
    end

    for (genvar k = 0; k < BPS; k++) begin : g_blk
      logic [BLK-1:0] a_b;
      logic [BLK-1:0] b_b;
      logic           cin_b;
      logic           cout_b;

      assign a_b = a_in[k*BLK +: BLK];
      assign b_b = b_in[k*BLK +: BLK];

      if (k == 0) begin : g_cin
        assign cin_b = c_in;
      end else begin : g_cin
        assign cin_b = g_blk[k-1].cout_b;
      end

      if (s == 0 && k == 0) begin : g_add
        logic [BLK:0] sum;
        assign sum          = {1'b0, a_b} + {1'b0, b_b} + {{BLK{1'b0}}, cin_b};
        assign blk_sum[k]   = sum[BLK-1:0];
        assign cout_b       = sum[BLK];
      end else begin : g_add
        logic [BLK:0] sum0;
        logic [BLK:0] sum1;
        assign sum0 = {1'b0, a_b} + {1'b0, b_b};
        assign sum1 = {1'b0, a_b} + {1'b0, b_b} + {{BLK{1'b0}}, 1'b1};
        assign {cout_b, blk_sum[k]} = cin_b ? sum1 : sum0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= g_blk[BPS-1].cout_b;
        r_q <= r_d;
      end
    end

    if (s < STAGES - 1) begin : g_hold
      logic [WS-SW-1:0] a_q;
      logic [WS-SW-1:0] b_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[WS-1:SW];
          b_q <= b_in[WS-1:SW];
        end
      end
    end else begin : g_flags
      // Flags are registered so they clear with reset instead of decoding
      // the zeroed result as "zero".
      logic ovf_q;
      logic zero_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= (a_in[WS-1] == b_in[WS-1]) && (r_d[RW-1] != a_in[WS-1]);
          zero_q <= ~|r_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.dout      = g_stage[STAGES-1].r_q;
  assign bus.carry_out = g_stage[STAGES-1].c_q;
  assign bus.overflow  = g_stage[STAGES-1].g_flags.ovf_q;
  assign bus.zero      = g_stage[STAGES-1].g_flags.zero_q;
endmodule

// File: tb/tb_csa_pipe_addsub.sv
// tb_csa_pipe_addsub
//   Directed vector table, back-pressure, mid-stream reset and a random
//   scoreboard run for csa_pipe_addsub at WIDTH=32, BLK=8, STAGES=2.
module tb_csa_pipe_addsub;
  localparam int W = 32;
  localparam int NV = 10;
  localparam int NRND = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_pipe_addsub_if #(.WIDTH(W)) bus ();

  csa_pipe_addsub #(.WIDTH(W), .BLK(8), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] d;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vt[NV];
  int n_checks = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load(input int i);
    bus.din1     = vt[i].a;
    bus.din2     = vt[i].b;
    bus.sub      = vt[i].sub;
    bus.carry_in = vt[i].cin;
  endtask

  // {carry_out, overflow, zero, dout} from plain wide arithmetic
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    logic [W-1:0] eb;
    logic [W:0]   s;
    logic         ov;
    eb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, cin ^ sub};
    ov = (a[W-1] == eb[W-1]) && (s[W-1] != a[W-1]);
    return {s[W], ov, (s[W-1:0] == '0), s[W-1:0]};
  endfunction

  task automatic run_one(input int i, input string tag);
    int lat;
    load(i);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_dout"}, bus.dout, vt[i].d);
    chk({tag, "_carry"}, bus.carry_out, vt[i].co);
    chk({tag, "_ovf"}, bus.overflow, vt[i].ov);
    chk({tag, "_zero"}, bus.zero, vt[i].z);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int idx_in, idx_out, stall_left, ghost, n_acc, n_emit;
    logic [W-1:0] stall_ref;
    logic acc, emit;
    logic [W+2:0] q[$];
    logic [W+2:0] exp;
    logic [W-1:0] ra, rb;
    logic rs, rc;

    //        a              b              sub   cin   dout           co    ov    z
    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[2] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFE, 1'b1, 1'b1, 1'b0};
    vt[3] = '{32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vt[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[6] = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
    vt[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};
    vt[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.din1      = '0;
    bus.din2      = '0;
    bus.sub       = 1'b0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_carry", bus.carry_out, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // directed table
    for (int i = 0; i < NV; i++) run_one(i, $sformatf("vec%0d", i));

    // back-pressure: 4 back-to-back ops, 3-cycle stall after the first result
    idx_in = 0;
    idx_out = 0;
    stall_left = -1;
    stall_ref = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.in_valid = (idx_in < 4);
      if (idx_in < 4) load(idx_in);
      bus.out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        if (stall_left == 3) stall_ref = bus.dout;
        else chk("stall_dout_stable", bus.dout, stall_ref);
      end
      acc  = bus.in_valid & bus.in_ready;
      emit = bus.out_valid & bus.out_ready;
      if (emit) begin
        if (idx_out < 4) chk($sformatf("bp_dout%0d", idx_out), bus.dout, vt[idx_out].d);
        idx_out++;
      end
      if (stall_left > 0) stall_left--;
      else if (stall_left < 0 && emit) stall_left = 3;
      tick();
      if (acc) idx_in++;
    end
    chk("bp_result_count", idx_out, 4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // reset with two ops in flight
    load(4);
    bus.in_valid = 1'b1;
    tick();
    load(5);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready_comb", bus.in_ready, 0);
    tick();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_dout", bus.dout, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    ghost = 0;
    repeat (6) begin
      tick();
      if (bus.out_valid) ghost++;
    end
    chk("midrst_ghost_results", ghost, 0);
    run_one(7, "midrst_new");

    // random stream against the model
    n_acc = 0;
    n_emit = 0;
    for (int cyc = 0; cyc < 4000 && n_emit < NRND; cyc++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = {ra[W-1], {(W-1){ra[0]}}};
      if ($urandom_range(0, 3) == 0) rb = {rb[W-1], {(W-1){rb[0]}}};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      bus.in_valid  = (n_acc < NRND) && ($urandom_range(0, 3) != 0);
      bus.din1      = ra;
      bus.din2      = rb;
      bus.sub       = rs;
      bus.carry_in  = rc;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ra, rb, rs, rc));
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_out_valid", bus.out_valid, 0);
        end else begin
          exp = q.pop_front();
          chk($sformatf("rnd_result%0d", n_emit),
              {bus.carry_out, bus.overflow, bus.zero, bus.dout}, exp);
        end
        n_emit++;
      end
      tick();
    end
    chk("rnd_emit_count", n_emit, NRND);
    chk("rnd_pending", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
